sysarr_row_ctrl: RTL and testbench
==================================

# sysarr_row_ctrl

Sequencer for one horizontal systolic row of eight chained PEs that pass partial sums from PE0 to PE7. It loads the row's weights, accepts input vectors through a valid/ready stream, and applies the per-lane input skew the psum chain needs. Row results are tracked and buffered in a credit-limited FIFO, because the array cannot stall. It sits between the input/weight buffers and the row, and drains results to the accumulator stage.

## Interface
- DATA_BW, 8, input element width (signed)
- WEIGHT_BW, 8, weight width (signed)
- PARTIAL_SUM_BW, 19, row result width (signed)
- MATRIX_SIZE, 8, PEs per row
- CNT_BW, 8, vector-count width
- FIFO_DEPTH, 16, result FIFO entries (≥ MATRIX_SIZE+1, power of 2)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  job request, sampled in IDLE only
- num_vec  in  CNT_BW  vectors in the job, latched on accepted start
- w_in  in  MATRIX_SIZE*WEIGHT_BW  weights, w0 in MSBs, latched on accepted start
- in_valid / in_ready  in / out  1  input vector handshake
- in_data  in  MATRIX_SIZE*DATA_BW  input vector, lane 0 in MSBs
- arr_we_rl  out  1  weight-load strobe to row
- arr_weights  out  MATRIX_SIZE*WEIGHT_BW  latched weights to row
- arr_din  out  MATRIX_SIZE*DATA_BW  skewed lanes to row, lane 0 in MSBs
- arr_result  in  PARTIAL_SUM_BW  PE7 psum output
- out_valid / out_ready  out / in  1  result handshake
- out_data  out  PARTIAL_SUM_BW  row result
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle job-complete pulse

## Operation
- Reset values: all outputs 0; state IDLE; skew registers, tag pipe and FIFO cleared; counters 0.
- States:
  - IDLE → LOAD on start && num_vec≠0. The controller latches num_vec and w_in. A start with num_vec==0 is ignored.
  - LOAD: arr_we_rl=1 for exactly one cycle; → STREAM.
  - STREAM: accept vectors; after the num_vec-th accept → DRAIN.
  - DRAIN: wait until the tag pipe and FIFO are both empty → DONE.
  - DONE: done=1 for one cycle; → IDLE.
  - start outside IDLE is ignored.
- arr_weights holds the latched value from LOAD until the next accepted start.
- in_ready = (state==STREAM) && (issued<num_vec) && (inflight+fifo_count < FIFO_DEPTH). Both counts are registered, so a pop frees its credit one cycle later.
- Skew: lane k passes through k register stages after the lane-0 register. Lanes of non-accepted cycles are driven 0.
- Tag pipe: a 1-bit shift register, length MATRIX_SIZE+1, set on accept. When a tag exits, arr_result is written to the FIFO.
- inflight = number of set tags.
- Results are passed unmodified: signed, no saturation or truncation. Order equals input order.
- FIFO write and pop in the same cycle are allowed; occupancy is unchanged.
- Credits guarantee the FIFO never overflows. A write to a full FIFO is a design error; assert it in simulation.
- rst mid-job aborts: state IDLE, all counters, skew, tags and FIFO cleared, pending results discarded, no done pulse.

## Timing
- Vector accepted in cycle t → lane k on arr_din in cycle t+1+k.
- arr_result is sampled in cycle t+1+MATRIX_SIZE, which is t+9 for the defaults.
- out_valid rises no earlier than t+2+MATRIX_SIZE.
- Back-to-back accepts are allowed: one vector per cycle when out_ready is held high.
- out_data and out_valid come from FIFO registers and are held stable while out_valid && !out_ready.
- Minimum job with one vector: accepted start to done, with out_ready=1, is 1 (LOAD) + 1 (accept) + MATRIX_SIZE+2 + 1 (DONE) cycles.

## Structure
- Shared package sysarr_pkg holds:
  - MATRIX_SIZE, DATA_BW, WEIGHT_BW, PARTIAL_SUM_BW;
  - the state encoding (IDLE, LOAD, STREAM, DRAIN, DONE);
  - ROW_LAT = MATRIX_SIZE+1.
- One sub-module: psum_fifo, a synchronous FIFO with count output. It is reused later for column-result buffering.
- Skew registers, tag pipe and FSM stay in this module.

## Test plan
- w_k=k+1 (w0=1…w7=8), one vector all lanes 1, out_ready=1 → out_data=36, out_valid in cycle t+10, done pulses once.
- w all 0xFF (−1), vector all 127, then all −128 back-to-back → 19-bit outputs −1016 then 1024, in order.
- num_vec=20, out_ready=0 → exactly 16 accepts, then in_ready=0. Then release out_ready → all 20 results, no loss or reorder, done after the last pop.
- rst asserted mid-STREAM after 5 accepts → all outputs 0 immediately. A new job afterwards yields only the new job's results.
- start while busy, and start with num_vec=0 in IDLE → both ignored: no arr_we_rl, busy unchanged.
- Random in_valid/out_ready, num_vec=200 → results match a reference dot-product model, arr_we_rl high exactly one cycle per job.

Source files
------------

// File: rtl/sysarr_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sysarr_pkg
// Brief   : Shared constants and state encoding for the systolic-array
//           row/column controllers.
// Rev     : 1.0  initial release
// ============================================================================
package sysarr_pkg;

    localparam int MATRIX_SIZE    = 8;
    localparam int DATA_BW        = 8;
    localparam int WEIGHT_BW      = 8;
    localparam int PARTIAL_SUM_BW = 19;

    // Cycles from an accepted vector to its psum appearing at PE7's output
    localparam int ROW_LAT = MATRIX_SIZE + 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } row_state_e;

endpackage
`default_nettype wire

// File: rtl/psum_fifo.sv
`default_nettype none
// ============================================================================
// Module  : psum_fifo
// Brief   : Synchronous FIFO with occupancy count. Head entry is presented
//           directly from storage so it stays stable until popped.
// Rev     : 1.0  initial release
// ============================================================================
module psum_fifo #(
    parameter int WIDTH = 19,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_wr_en,
    input  logic [WIDTH-1:0]           i_wr_data,
    input  logic                       i_rd_en,
    output logic [WIDTH-1:0]           o_rd_data,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [0:DEPTH-1];
    logic [WIDTH-1:0] mem_d [0:DEPTH-1];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;

    logic w_full;
    logic w_do_wr;
    logic w_do_rd;

    assign o_empty   = (count_q == '0);
    assign w_full    = (count_q == (AW+1)'(DEPTH));
    assign o_count   = count_q;
    assign o_rd_data = mem_q[rd_ptr_q];

    // A write into a full FIFO is only honoured when the head leaves the same cycle
    assign w_do_wr = i_wr_en && (!w_full || i_rd_en);
    assign w_do_rd = i_rd_en && !o_empty;

    // Next storage, pointers and occupancy
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_do_wr) begin
            mem_d[wr_ptr_q] = i_wr_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (w_do_rd) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({w_do_wr, w_do_rd})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Upstream credit logic must never let a result land in a full FIFO
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(i_wr_en && w_full && !i_rd_en));

endmodule
`default_nettype wire

// File: rtl/sysarr_row_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : sysarr_row_ctrl
// Brief   : Sequencer for one 8-PE systolic row: weight load, input stream
//           with per-lane skew, result tracking and credit-limited buffering.
// Rev     : 1.0  initial release
// ============================================================================
module sysarr_row_ctrl
    import sysarr_pkg::*;
#(
    parameter int CNT_BW     = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic [CNT_BW-1:0]                  num_vec,
    input  logic [MATRIX_SIZE*WEIGHT_BW-1:0]   w_in,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [MATRIX_SIZE*DATA_BW-1:0]     in_data,
    output logic                               arr_we_rl,
    output logic [MATRIX_SIZE*WEIGHT_BW-1:0]   arr_weights,
    output logic [MATRIX_SIZE*DATA_BW-1:0]     arr_din,
    input  logic [PARTIAL_SUM_BW-1:0]          arr_result,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [PARTIAL_SUM_BW-1:0]          out_data,
    output logic                               busy,
    output logic                               done
);

    localparam int FCNT_BW = $clog2(FIFO_DEPTH) + 1;
    // Wide enough for in-flight tags plus a full FIFO
    localparam int CRED_BW = $clog2(FIFO_DEPTH) + 2;

    row_state_e                         state_q, state_d;
    logic [CNT_BW-1:0]                  num_vec_q, num_vec_d;
    logic [CNT_BW-1:0]                  issued_q, issued_d;
    logic [MATRIX_SIZE*WEIGHT_BW-1:0]   weights_q, weights_d;
    logic [ROW_LAT-1:0]                 tag_q, tag_d;
    logic [CRED_BW-1:0]                 inflight_q, inflight_d;

    logic [FCNT_BW-1:0] w_fifo_count;
    logic               w_fifo_empty;
    logic               w_accept;
    logic               w_tag_exit;
    logic               w_pop;
    logic [CRED_BW-1:0] w_credits_used;
    logic               w_drain_empty;

    assign arr_weights    = weights_q;
    assign out_valid      = !w_fifo_empty;
    assign w_pop          = out_valid && out_ready;
    assign w_tag_exit     = tag_q[ROW_LAT-1];
    assign w_credits_used = inflight_q + CRED_BW'(w_fifo_count);

    assign in_ready = (state_q == ST_STREAM) && (issued_q < num_vec_q) &&
                      (w_credits_used < CRED_BW'(FIFO_DEPTH));
    assign w_accept = in_valid && in_ready;

    // Pipe and FIFO will both be empty next cycle; no tag can be exiting
    // while inflight is zero, so only a pop can change the FIFO here.
    assign w_drain_empty = (inflight_q == '0) &&
                           ((w_fifo_count == '0) ||
                            ((w_fifo_count == FCNT_BW'(1)) && w_pop));

    // FSM next-state, job latches and status outputs
    always_comb begin
        state_d   = state_q;
        num_vec_d = num_vec_q;
        issued_d  = issued_q;
        weights_d = weights_q;
        arr_we_rl = 1'b0;
        busy      = (state_q != ST_IDLE);
        done      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && (num_vec != '0)) begin
                    state_d   = ST_LOAD;
                    num_vec_d = num_vec;
                    weights_d = w_in;
                    issued_d  = '0;
                end
            end
            ST_LOAD: begin
                arr_we_rl = 1'b1;
                state_d   = ST_STREAM;
            end
            ST_STREAM: begin
                if (w_accept) begin
                    issued_d = issued_q + CNT_BW'(1);
                    if ((issued_q + CNT_BW'(1)) == num_vec_q) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (w_drain_empty) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Result tag pipe mirrors the row latency; inflight counts set tags
    always_comb begin
        tag_d      = {tag_q[ROW_LAT-2:0], w_accept};
        inflight_d = inflight_q;
        if (w_accept && !w_tag_exit) begin
            inflight_d = inflight_q + CRED_BW'(1);
        end else if (!w_accept && w_tag_exit) begin
            inflight_d = inflight_q - CRED_BW'(1);
        end
    end

    // Controller state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            num_vec_q  <= '0;
            issued_q   <= '0;
            weights_q  <= '0;
            tag_q      <= '0;
            inflight_q <= '0;
        end else begin
            state_q    <= state_d;
            num_vec_q  <= num_vec_d;
            issued_q   <= issued_d;
            weights_q  <= weights_d;
            tag_q      <= tag_d;
            inflight_q <= inflight_d;
        end
    end

    // Input skew: lane k is delayed k extra cycles so it meets the psum
    // arriving from PE(k-1)
    for (genvar k = 0; k < MATRIX_SIZE; k++) begin : g_lane
        logic [DATA_BW-1:0] sr_q [0:k];
        logic [DATA_BW-1:0] sr_d [0:k];

        // Shift the lane, injecting zero on cycles without an accept
        always_comb begin
            sr_d[0] = w_accept ? in_data[(MATRIX_SIZE-1-k)*DATA_BW +: DATA_BW] : '0;
            for (int j = 1; j <= k; j++) begin
                sr_d[j] = sr_q[j-1];
            end
        end

        // Lane skew registers
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int j = 0; j <= k; j++) begin
                    sr_q[j] <= '0;
                end
            end else begin
                sr_q <= sr_d;
            end
        end

        assign arr_din[(MATRIX_SIZE-1-k)*DATA_BW +: DATA_BW] = sr_q[k];
    end

    psum_fifo #(
        .WIDTH (PARTIAL_SUM_BW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_tag_exit),
        .i_wr_data (arr_result),
        .i_rd_en   (w_pop),
        .o_rd_data (out_data),
        .o_empty   (w_fifo_empty),
        .o_count   (w_fifo_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_sysarr_row_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_sysarr_row_ctrl
// Brief   : Self-checking bench for sysarr_row_ctrl with a behavioural PE row
//           and a dot-product scoreboard.
// Rev     : 1.0  initial release
// ============================================================================
module tb_sysarr_row_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  num_vec = '0;
    logic [63:0] w_in = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_data = '0;
    logic        arr_we_rl;
    logic [63:0] arr_weights;
    logic [63:0] arr_din;
    logic [18:0] arr_result;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [18:0] out_data;
    logic        busy;
    logic        done;

    sysarr_row_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .num_vec     (num_vec),
        .w_in        (w_in),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .arr_we_rl   (arr_we_rl),
        .arr_weights (arr_weights),
        .arr_din     (arr_din),
        .arr_result  (arr_result),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural PE row: PE k adds w_k*x_k to the psum from PE k-1
    logic [18:0] pe_q [0:7];
    always @(posedge clk) begin
        for (int k = 0; k < 8; k++) begin
            int prod;
            prod = $signed(arr_weights[(7-k)*8 +: 8]) * $signed(arr_din[(7-k)*8 +: 8]);
            pe_q[k] <= ((k == 0) ? 19'd0 : pe_q[k-1]) + prod[18:0];
        end
    end
    assign arr_result = pe_q[7];

    function automatic logic [18:0] dot(input logic [63:0] w, input logic [63:0] x);
        int s;
        int p;
        s = 0;
        for (int k = 0; k < 8; k++) begin
            p = $signed(w[(7-k)*8 +: 8]) * $signed(x[(7-k)*8 +: 8]);
            s = s + p;
        end
        return s[18:0];
    endfunction

    int n_vec = 0;
    int n_err = 0;

    logic [63:0] cur_w = '0;
    logic [18:0] exp_q [$];
    logic [18:0] out_log [$];
    int acc_cnt, pop_cnt, we_cnt, done_cnt;
    int done_cyc, first_ov_cyc, last_pop_cyc, last_acc_cyc, first_acc_cyc, job_start_cyc;

    // Monitor: sampled mid-cycle, pushes expectations on accept, checks on pop
    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready) begin
                exp_q.push_back(dot(cur_w, in_data));
                acc_cnt++;
                last_acc_cyc = cyc;
                if (first_acc_cyc < 0) first_acc_cyc = cyc;
            end
            if (out_valid && first_ov_cyc < 0) first_ov_cyc = cyc;
            if (out_valid && out_ready) begin
                logic [18:0] e;
                pop_cnt++;
                last_pop_cyc = cyc;
                out_log.push_back(out_data);
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL scoreboard_extra: out_data=%0d with no result expected", $signed(out_data));
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e) begin
                        n_err++;
                        $display("FAIL scoreboard: out_data=%0d required %0d", $signed(out_data), $signed(e));
                    end
                end
            end
            if (arr_we_rl) we_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        exp_q.delete();
        out_log.delete();
        acc_cnt = 0; pop_cnt = 0; we_cnt = 0; done_cnt = 0;
        done_cyc = -1; first_ov_cyc = -1; last_pop_cyc = -1;
        last_acc_cyc = -1; first_acc_cyc = -1; job_start_cyc = -1;
    endtask

    task automatic start_job(input logic [7:0] nv, input logic [63:0] w);
        start = 1'b1; num_vec = nv; w_in = w; cur_w = w;
        job_start_cyc = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic send_vec(input logic [63:0] d, input int budget);
        int n;
        bit ok;
        n = 0; ok = 1'b0;
        in_valid = 1'b1; in_data = d;
        while (!ok && n < budget) begin
            @(negedge clk);
            ok = in_ready;
            tick();
            n++;
        end
        in_valid = 1'b0;
        if (!ok) begin
            n_vec++; n_err++;
            $display("FAIL send_timeout: in_ready=0 required 1 within %0d cycles", budget);
        end
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            tick();
            n++;
        end
        if (done_cnt == 0) begin
            n_vec++; n_err++;
            $display("FAIL done_timeout: done=0 required 1 within %0d cycles", budget);
        end
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        n_vec++;
        if ({arr_we_rl, arr_weights, arr_din, out_valid, out_data, busy, done, in_ready} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: we=%0b w=%h din=%h ov=%0b od=%h busy=%0b done=%0b rdy=%0b required all 0",
                     arr_we_rl, arr_weights, arr_din, out_valid, out_data, busy, done, in_ready);
        end
        rst = 1'b0;
        repeat (2) tick();
        n_vec++;
        if ({busy, in_ready, out_valid} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_idle: busy/rdy/ov=%b required 000", {busy, in_ready, out_valid});
        end
    endtask

    task automatic test_single();
        clear_stats();
        out_ready = 1'b1;
        start_job(8'd1, {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8});
        send_vec({8{8'd1}}, 20);
        wait_done(100);
        n_vec++;
        if (first_ov_cyc !== last_acc_cyc + 10) begin
            n_err++;
            $display("FAIL single_latency: out_valid at t+%0d required t+10", first_ov_cyc - last_acc_cyc);
        end
        n_vec++;
        if (out_log.size() != 1 || out_log[0] !== 19'd36) begin
            n_err++;
            $display("FAIL single_value: %0d results, first=%0d required 1 result of 36",
                     out_log.size(), (out_log.size() > 0) ? $signed(out_log[0]) : 0);
        end
        n_vec++;
        if (done_cyc - job_start_cyc != 13) begin
            n_err++;
            $display("FAIL single_job_len: start-to-done=%0d required 13", done_cyc - job_start_cyc);
        end
        n_vec++;
        if (done_cnt != 1 || we_cnt != 1) begin
            n_err++;
            $display("FAIL single_pulses: done=%0d we=%0d required 1 and 1", done_cnt, we_cnt);
        end
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL single_idle: busy=%0b required 0", busy);
        end
    endtask

    task automatic test_signed_back_to_back();
        logic [18:0] e0;
        logic [18:0] e1;
        e0 = 19'h7FC08;   // -1016
        e1 = 19'd1024;
        clear_stats();
        out_ready = 1'b1;
        start_job(8'd2, {8{8'hFF}});
        send_vec({8{8'd127}}, 20);
        send_vec({8{8'h80}}, 20);
        wait_done(100);
        n_vec++;
        if (out_log.size() != 2 || out_log[0] !== e0 || out_log[1] !== e1) begin
            n_err++;
            $display("FAIL signed_values: got %0d results (%0d,%0d) required -1016 then 1024",
                     out_log.size(),
                     (out_log.size() > 0) ? $signed(out_log[0]) : 0,
                     (out_log.size() > 1) ? $signed(out_log[1]) : 0);
        end
        n_vec++;
        if (last_acc_cyc - first_acc_cyc != 1) begin
            n_err++;
            $display("FAIL back_to_back: accepts %0d cycles apart required 1", last_acc_cyc - first_acc_cyc);
        end
    endtask

    task automatic test_credit();
        logic [63:0] d17;
        clear_stats();
        out_ready = 1'b0;
        start_job(8'd20, {$urandom, $urandom});
        for (int i = 0; i < 16; i++) send_vec({$urandom, $urandom}, 20);
        d17 = {$urandom, $urandom};
        in_valid = 1'b1; in_data = d17;
        repeat (30) tick();
        @(negedge clk);
        n_vec++;
        if (acc_cnt != 16 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL credit_limit: accepts=%0d in_ready=%0b required 16 and 0", acc_cnt, in_ready);
        end
        n_vec++;
        if (out_valid !== 1'b1 || exp_q.size() == 0 || out_data !== exp_q[0]) begin
            n_err++;
            $display("FAIL credit_hold: ov=%0b out_data=%0d required 1 and %0d",
                     out_valid, $signed(out_data), (exp_q.size() > 0) ? $signed(exp_q[0]) : 0);
        end
        tick();
        out_ready = 1'b1;
        send_vec(d17, 50);
        for (int i = 0; i < 3; i++) send_vec({$urandom, $urandom}, 50);
        wait_done(300);
        n_vec++;
        if (pop_cnt != 20 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL credit_drain: pops=%0d left=%0d required 20 and 0", pop_cnt, exp_q.size());
        end
        n_vec++;
        if (done_cnt != 1 || done_cyc != last_pop_cyc + 1) begin
            n_err++;
            $display("FAIL credit_done: done=%0d at pop+%0d required 1 at pop+1", done_cnt, done_cyc - last_pop_cyc);
        end
    endtask

    task automatic test_abort();
        clear_stats();
        out_ready = 1'b1;
        start_job(8'd10, {$urandom, $urandom});
        for (int i = 0; i < 5; i++) send_vec({$urandom, $urandom}, 20);
        rst = 1'b1;
        #1;
        n_vec++;
        if ({arr_we_rl, arr_weights, arr_din, out_valid, out_data, busy, done, in_ready} !== '0) begin
            n_err++;
            $display("FAIL abort_outputs: busy=%0b ov=%0b din=%h w=%h required all 0",
                     busy, out_valid, arr_din, arr_weights);
        end
        repeat (2) tick();
        rst = 1'b0;
        clear_stats();
        repeat (20) tick();
        n_vec++;
        if (done_cnt != 0 || pop_cnt != 0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL abort_quiet: done=%0d pops=%0d busy=%0b required 0 0 0", done_cnt, pop_cnt, busy);
        end
        start_job(8'd3, {$urandom, $urandom});
        for (int i = 0; i < 3; i++) send_vec({$urandom, $urandom}, 20);
        wait_done(100);
        n_vec++;
        if (pop_cnt != 3 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL abort_newjob: pops=%0d left=%0d required 3 and 0", pop_cnt, exp_q.size());
        end
    endtask

    task automatic test_ignored_start();
        logic [63:0] w1;
        w1 = {$urandom, $urandom};
        clear_stats();
        out_ready = 1'b1;
        start_job(8'd2, w1);
        start = 1'b1; num_vec = 8'd5; w_in = ~w1;
        tick();
        start = 1'b0;
        send_vec({$urandom, $urandom}, 20);
        send_vec({$urandom, $urandom}, 20);
        wait_done(100);
        n_vec++;
        if (we_cnt != 1 || pop_cnt != 2 || arr_weights !== w1) begin
            n_err++;
            $display("FAIL busy_start: we=%0d pops=%0d weights=%h required 1 2 %h", we_cnt, pop_cnt, arr_weights, w1);
        end
        start = 1'b1; num_vec = 8'd0; w_in = ~w1;
        tick();
        start = 1'b0;
        @(negedge clk);
        n_vec++;
        if (arr_we_rl !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL zero_start: we=%0b busy=%0b required 0 0", arr_we_rl, busy);
        end
        repeat (5) tick();
        n_vec++;
        if (we_cnt != 1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL zero_start_later: we=%0d busy=%0b required 1 0", we_cnt, busy);
        end
    endtask

    task automatic test_random();
        int n;
        clear_stats();
        start_job(8'd200, {$urandom, $urandom});
        n = 0;
        while (done_cnt == 0 && n < 5000) begin
            in_valid  = (acc_cnt < 200) && ($urandom_range(3) != 0);
            in_data   = {$urandom, $urandom};
            out_ready = ($urandom_range(2) != 0);
            tick();
            n++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        if (done_cnt == 0) begin
            n_vec++; n_err++;
            $display("FAIL random_timeout: done=0 required 1 within 5000 cycles");
        end
        tick();
        n_vec++;
        if (acc_cnt != 200 || pop_cnt != 200 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL random_count: acc=%0d pops=%0d left=%0d required 200 200 0", acc_cnt, pop_cnt, exp_q.size());
        end
        n_vec++;
        if (we_cnt != 1 || done_cnt != 1) begin
            n_err++;
            $display("FAIL random_pulses: we=%0d done=%0d required 1 1", we_cnt, done_cnt);
        end
    endtask

    initial begin
        clear_stats();
        test_reset();
        test_single();
        test_signed_back_to_back();
        test_credit();
        test_abort();
        test_ignored_start();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
